// File: rtl/lsu_sram_ctrl.sv
// Load/store sequencer in front of a byte-per-location SRAM: loads gather one byte per cycle,
// stores are issued as a single masked write followed by a settle cycle. One response per request.
module lsu_sram_ctrl #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_csb,
    output logic                  mem_web,
    output logic [NUM_WMASKS-1:0] mem_wmask,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    typedef enum logic [2:0] {IDLE, RD, WR, WSETTLE, RSP} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] base;
    logic [1:0]            size_q, cnt, last, req_last;
    logic                  uns_q, err_q;
    logic [DATA_WIDTH-1:0] wdata_q, asm_q, asm_nxt, ext;
    logic [ADDR_WIDTH-1:0] addr_hold;
    logic [DATA_WIDTH-1:0] din_hold;
    logic [ADDR_WIDTH:0]   end_addr;
    logic                  accept, req_err, sign_bit;
    logic                  unused_dout;

    assign unused_dout = ^mem_dout[DATA_WIDTH-1:8];
    assign accept      = req_valid && req_ready;

    always_comb begin
        case (req_size)
            2'd0:    req_last = 2'd0;
            2'd1:    req_last = 2'd1;
            default: req_last = 2'd3;
        endcase
        case (size_q)
            2'd0:    last = 2'd0;
            2'd1:    last = 2'd1;
            default: last = 2'd3;
        endcase
    end

    // Carry out of the last-byte address means the access would run off the top of the SRAM.
    assign end_addr = {1'b0, req_addr} + (ADDR_WIDTH+1)'(req_last);
    assign req_err  = (req_size == 2'd3) || end_addr[ADDR_WIDTH];

    always_comb begin
        asm_nxt = asm_q;
        asm_nxt[int'(cnt)*8 +: 8] = mem_dout[7:0];
        ext = asm_nxt;
        case (size_q)
            2'd0: begin
                sign_bit = ~uns_q & asm_nxt[7];
                ext = {{(DATA_WIDTH-8){sign_bit}}, asm_nxt[7:0]};
            end
            2'd1: begin
                sign_bit = ~uns_q & asm_nxt[15];
                ext = {{(DATA_WIDTH-16){sign_bit}}, asm_nxt[15:0]};
            end
            default: sign_bit = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        req_ready = (state == IDLE);
        rsp_valid = (state == RSP);
        rsp_err   = (state == RSP) && err_q;
        mem_csb   = 1'b1;
        mem_web   = 1'b0;
        mem_wmask = '0;
        mem_addr  = addr_hold;
        mem_din   = din_hold;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)     state_nxt = RSP;
                    else if (req_we) state_nxt = WR;
                    else             state_nxt = RD;
                end
            end
            RD: begin
                mem_csb  = 1'b0;
                mem_addr = base + ADDR_WIDTH'(cnt);
                if (cnt == last) state_nxt = RSP;
            end
            WR: begin
                mem_csb  = 1'b0;
                mem_web  = 1'b1;
                mem_addr = base;
                mem_din  = wdata_q;
                for (int i = 0; i < NUM_WMASKS; i++) mem_wmask[i] = (i <= int'(last));
                state_nxt = WSETTLE;
            end
            WSETTLE: state_nxt = RSP;
            RSP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            base      <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            asm_q     <= '0;
            cnt       <= '0;
            rsp_rdata <= '0;
            addr_hold <= '0;
            din_hold  <= '0;
        end else begin
            state     <= state_nxt;
            addr_hold <= mem_addr;
            din_hold  <= mem_din;
            if (accept) begin
                base    <= req_addr;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                err_q   <= req_err;
                wdata_q <= req_wdata;
                asm_q   <= '0;
                cnt     <= '0;
            end
            if (state == RD) begin
                asm_q <= asm_nxt;
                cnt   <= cnt + 2'd1;
                if (cnt == last) rsp_rdata <= ext;
            end
        end
    end

endmodule

// File: tb/tb_lsu_sram_ctrl.sv
// Directed bench for lsu_sram_ctrl with a byte-per-location SRAM model whose writes commit one cycle late.
module tb_lsu_sram_ctrl;
    localparam int AW = 13;
    localparam int DW = 32;
    localparam int NM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          mem_csb, mem_web;
    logic [NM-1:0] mem_wmask;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;

    always #5 clk = ~clk;

    lsu_sram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NM)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_csb(mem_csb), .mem_web(mem_web), .mem_wmask(mem_wmask),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // SRAM model: latches write inputs at the WR edge, commits byte k to addr+k one edge later.
    logic [7:0]    sram [0:(1<<AW)-1];
    logic          pend_v = 1'b0;
    logic [AW-1:0] pend_a;
    logic [DW-1:0] pend_d;
    logic [NM-1:0] pend_m;

    always @(posedge clk) begin
        if (pend_v)
            for (int k = 0; k < NM; k++)
                if (pend_m[k]) sram[AW'(pend_a + AW'(k))] <= pend_d[k*8 +: 8];
        pend_v <= !mem_csb && mem_web;
        pend_a <= mem_addr;
        pend_d <= mem_din;
        pend_m <= mem_wmask;
    end

    assign mem_dout = {24'h0, sram[mem_addr]};

    int            web_cyc = 0;
    int            csb_cyc = 0;
    logic [NM-1:0] seen_wmask = '0;

    always @(negedge clk) begin
        if (!mem_csb) csb_cyc++;
        if (mem_web) begin
            web_cyc++;
            seen_wmask = mem_wmask;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          output int lat, output logic err, output logic [DW-1:0] rdata,
                          output int webs, output int csbs);
        int n, w0, c0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        w0 = web_cyc;
        c0 = csb_cyc;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
        err   = rsp_err;
        rdata = rsp_rdata;
        webs  = web_cyc - w0;
        csbs  = csb_cyc - c0;
    endtask

    int            lat, webs, csbs, pulses;
    logic          err;
    logic [DW-1:0] rdata;

    initial begin
        for (int i = 0; i < (1 << AW); i++) sram[i] = 8'h00;
        sram[13'h1FFE] = 8'h34;
        sram[13'h1FFF] = 8'h92;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_mem_csb", 32'(mem_csb), 32'd1);
        check("rst_mem_web", 32'(mem_web), 32'd0);
        check("rst_mem_wmask", 32'(mem_wmask), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_din", mem_din, 32'h0);

        // Word store then word load.
        do_req(1'b1, 2'd2, 1'b0, 13'h0100, 32'hDEADBEEF, lat, err, rdata, webs, csbs);
        check("sw_lat", 32'(lat), 32'd3);
        check("sw_err", 32'(err), 32'd0);
        check("sw_rdata_hold", rdata, 32'h0);
        check("sw_web_cycles", 32'(webs), 32'd1);
        check("sw_wmask", 32'(seen_wmask), 32'h0000000F);
        do_req(1'b0, 2'd2, 1'b0, 13'h0100, 32'h0, lat, err, rdata, webs, csbs);
        check("lw_lat", 32'(lat), 32'd5);
        check("lw_err", 32'(err), 32'd0);
        check("lw_rdata", rdata, 32'hDEADBEEF);

        // Sub-word loads with extension.
        do_req(1'b0, 2'd0, 1'b0, 13'h0103, 32'h0, lat, err, rdata, webs, csbs);
        check("lb_lat", 32'(lat), 32'd2);
        check("lb_rdata", rdata, 32'hFFFFFFDE);
        do_req(1'b0, 2'd0, 1'b1, 13'h0103, 32'h0, lat, err, rdata, webs, csbs);
        check("lbu_rdata", rdata, 32'h000000DE);
        do_req(1'b0, 2'd1, 1'b0, 13'h0102, 32'h0, lat, err, rdata, webs, csbs);
        check("lh_lat", 32'(lat), 32'd3);
        check("lh_rdata", rdata, 32'hFFFFDEAD);
        do_req(1'b0, 2'd1, 1'b1, 13'h0100, 32'h0, lat, err, rdata, webs, csbs);
        check("lhu_rdata", rdata, 32'h0000BEEF);

        // Byte store immediately followed by a load of the same byte.
        do_req(1'b1, 2'd0, 1'b0, 13'h0101, 32'h1234565A, lat, err, rdata, webs, csbs);
        check("sb_web_cycles", 32'(webs), 32'd1);
        check("sb_wmask", 32'(seen_wmask), 32'h00000001);
        check("sb_rdata_hold", rdata, 32'h0000BEEF);
        do_req(1'b0, 2'd0, 1'b1, 13'h0101, 32'h0, lat, err, rdata, webs, csbs);
        check("raw_rdata", rdata, 32'h0000005A);
        do_req(1'b0, 2'd0, 1'b1, 13'h0102, 32'h0, lat, err, rdata, webs, csbs);
        check("sb_neighbour", rdata, 32'h000000AD);

        // Out-of-range and illegal-size requests.
        do_req(1'b1, 2'd2, 1'b0, 13'h1FFE, 32'hCAFEF00D, lat, err, rdata, webs, csbs);
        check("cross_lat", 32'(lat), 32'd1);
        check("cross_err", 32'(err), 32'd1);
        check("cross_web", 32'(webs), 32'd0);
        check("cross_csb", 32'(csbs), 32'd0);
        check("cross_rdata_hold", rdata, 32'h000000AD);
        do_req(1'b0, 2'd3, 1'b0, 13'h0000, 32'h0, lat, err, rdata, webs, csbs);
        check("size3_lat", 32'(lat), 32'd1);
        check("size3_err", 32'(err), 32'd1);
        check("size3_csb", 32'(csbs), 32'd0);
        do_req(1'b0, 2'd1, 1'b0, 13'h1FFE, 32'h0, lat, err, rdata, webs, csbs);
        check("top_half_err", 32'(err), 32'd0);
        check("top_half_rdata", rdata, 32'hFFFF9234);

        // Reset in the third RD cycle of a word load.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 13'h0100;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        pulses = 0;
        @(negedge clk);
        if (rsp_valid) pulses++;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid) pulses++;
            @(negedge clk);
        end
        check("abort_no_rsp", 32'(pulses), 32'd0);
        do_req(1'b0, 2'd0, 1'b1, 13'h0103, 32'h0, lat, err, rdata, webs, csbs);
        check("post_rst_lb", rdata, 32'h000000DE);

        // req_valid held across three back-to-back byte loads.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b1; req_addr = 13'h0100;
        for (int i = 0; i < 9; i++) begin
            check("b2b_ready", 32'(req_ready), (i % 3 == 0) ? 32'd1 : 32'd0);
            check("b2b_rsp_valid", 32'(rsp_valid), (i % 3 == 2) ? 32'd1 : 32'd0);
            if (rsp_valid) check("b2b_rdata", rsp_rdata, 32'h000000EF);
            if (i == 8) req_valid = 1'b0;
            @(negedge clk);
        end
        check("b2b_idle_ready", 32'(req_ready), 32'd1);
        check("b2b_no_extra_rsp", 32'(rsp_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
